// File: rtl/fetch_stage_ctrl_if.sv
// fetch_stage_ctrl_if: hazard/branch control inputs, imem port and IF/ID outputs of the fetch stage.
// FETCH_PERF_CNT_EN adds the stall_cycles / flush_count observation outputs.
interface fetch_stage_ctrl_if #(parameter int PC_W = 32);
    logic            pc_write;
    logic            ifid_write;
    logic            if_flush;
    logic [PC_W-1:0] branch_target;
    logic [31:0]     imem_instr;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     ifid_instr;
    logic [PC_W-1:0] ifid_pc_plus4;
    logic            ifid_valid;
    logic [4:0]      ifid_rs;
    logic [4:0]      ifid_rt;
    logic            stall_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     flush_count;
    modport master (output pc_write, ifid_write, if_flush, branch_target, imem_instr,
                    input imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, ifid_rs, ifid_rt,
                    stall_err, stall_cycles, flush_count);
    modport slave  (input pc_write, ifid_write, if_flush, branch_target, imem_instr,
                    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, ifid_rs, ifid_rt,
                    stall_err, stall_cycles, flush_count);
`else
    modport master (output pc_write, ifid_write, if_flush, branch_target, imem_instr,
                    input imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, ifid_rs, ifid_rt,
                    stall_err);
    modport slave  (input pc_write, ifid_write, if_flush, branch_target, imem_instr,
                    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, ifid_rs, ifid_rt,
                    stall_err);
`endif
endinterface

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC and IF/ID register owner with stall/flush handling and a runaway-stall watchdog.
// Define FETCH_PERF_CNT_EN to add saturating stall-cycle and flush counters.
module fetch_stage_ctrl #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              MAX_STALL = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    fetch_stage_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_STALL);

    typedef enum logic {RUN, STALL} state_t;

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc4;
    logic            r_valid;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_stall_err;
    logic [PC_W-1:0] w_pc_plus4;
    logic            w_stall;
    logic [CW-1:0]   w_cnt_nxt;

    assign w_pc_plus4 = r_pc + PC_W'(4);
    assign w_stall    = !bus.pc_write && !bus.if_flush;
    // first stall cycle after RUN counts as 1; saturate so the counter never wraps
    assign w_cnt_nxt  = (r_state == RUN) ? CW'(1) : (r_cnt == MAX_C) ? MAX_C : r_cnt + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pc <= bus.if_flush ? {bus.branch_target[PC_W-1:2], 2'b00} :
                    bus.pc_write ? w_pc_plus4 : r_pc;
            if (bus.if_flush) begin
                r_instr <= '0;
                r_pc4   <= '0;
                r_valid <= 1'b0;
            end else if (bus.ifid_write) begin
                r_instr <= bus.imem_instr;
                r_pc4   <= w_pc_plus4;
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stall_err <= 1'b0;
        end else if (w_stall) begin
            r_state <= STALL;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == MAX_C) r_stall_err <= 1'b1;
        end else begin
            r_state <= RUN;
            r_cnt   <= '0;
        end
    end

    assign bus.imem_addr     = r_pc;
    assign bus.ifid_instr    = r_instr;
    assign bus.ifid_pc_plus4 = r_pc4;
    assign bus.ifid_valid    = r_valid;
    assign bus.ifid_rs       = r_instr[25:21];
    assign bus.ifid_rt       = r_instr[20:16];
    assign bus.stall_err     = r_stall_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (bus.if_flush && !(&r_flush_count)) r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`endif
endmodule
